// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 800x600 timing defaults, frame total derivation and the
// lock FSM state type shared by the sync decoder files.
package vga_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE    = 800;
  localparam int unsigned DEF_H_FP        = 40;
  localparam int unsigned DEF_H_SYNC      = 128;
  localparam int unsigned DEF_H_BP        = 88;
  localparam int unsigned DEF_V_ACTIVE    = 600;
  localparam int unsigned DEF_V_FP        = 1;
  localparam int unsigned DEF_V_SYNC      = 4;
  localparam int unsigned DEF_V_BP        = 23;
  localparam int unsigned DEF_LOCK_FRAMES = 2;

  // Total period of one axis: visible + front porch + sync + back porch.
  function automatic int unsigned timing_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned DEF_H_TOTAL =
    timing_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int unsigned DEF_V_TOTAL =
    timing_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: stage-1 register of one sync line plus leading-edge detector.
// The sync level is normalised to active-high before edge detection.
module sync_edge #(
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  output logic lead_edge
);

  logic sync_act;
  logic sync_act_d;

  // capture the sync line and keep one cycle of history for the edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_act   <= 1'b0;
      sync_act_d <= 1'b0;
    end else begin
      sync_act   <= (sync_in == ACTIVE_HIGH);
      sync_act_d <= sync_act;
    end
  end

  assign lead_edge = sync_act & ~sync_act_d;

endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers beam position, timing lock and the pixel stream
// from raw VGA sync and colour inputs. Defining VGA_DECODER_CHECKSUM_EN adds
// a per-frame 16-bit sum of delivered pixels on frame_checksum.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE         = DEF_H_ACTIVE,
  parameter int unsigned H_FP             = DEF_H_FP,
  parameter int unsigned H_SYNC           = DEF_H_SYNC,
  parameter int unsigned H_BP             = DEF_H_BP,
  parameter int unsigned V_ACTIVE         = DEF_V_ACTIVE,
  parameter int unsigned V_FP             = DEF_V_FP,
  parameter int unsigned V_SYNC           = DEF_V_SYNC,
  parameter int unsigned V_BP             = DEF_V_BP,
  parameter bit          SYNC_ACTIVE_HIGH = 1'b1,
  parameter int unsigned LOCK_FRAMES      = DEF_LOCK_FRAMES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic [3:0]  vga_r,
  input  logic [3:0]  vga_g,
  input  logic [3:0]  vga_b,
  output logic [10:0] beam_x,
  output logic [9:0]  beam_y,
  output logic        pixel_valid,
  output logic [11:0] pixel_rgb,
  output logic        locked,
  output logic        frame_start,
  output logic [7:0]  error_count,
  output logic [15:0] frame_checksum
);

  localparam logic [10:0] H_TOT   = 11'(timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam logic [10:0] H_LAST  = H_TOT - 11'd1;
  localparam logic [10:0] H_START = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_END   = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0]  V_TOT   = 10'(timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
  localparam logic [9:0]  V_LAST  = V_TOT - 10'd1;
  localparam logic [9:0]  V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [7:0]  LOCK_N  = 8'(LOCK_FRAMES);

  logic        hs_edge, vs_edge;
  logic [11:0] rgb_q;
  logic [10:0] hcnt, hcnt_nx;
  logic [9:0]  vcnt, vcnt_nx;
  logic        line_err, frame_err, any_err;
  logic        in_active, valid_nx;
  logic        err_inc;
  logic [7:0]  clean_cnt, clean_nx;
  lock_state_t state, state_nx;

  sync_edge #(.ACTIVE_HIGH(SYNC_ACTIVE_HIGH)) u_hs_edge (
    .clk       (clk),
    .rst       (rst),
    .sync_in   (vga_hs),
    .lead_edge (hs_edge)
  );

  sync_edge #(.ACTIVE_HIGH(SYNC_ACTIVE_HIGH)) u_vs_edge (
    .clk       (clk),
    .rst       (rst),
    .sync_in   (vga_vs),
    .lead_edge (vs_edge)
  );

  // stage-1 colour register, aligned with the sync stage-1 registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rgb_q <= '0;
    else      rgb_q <= {vga_r, vga_g, vga_b};
  end

  // Position counters. The *_nx values describe the current stage-1 pixel,
  // so the active-area decode uses them rather than the registered counts.
  always_comb begin
    hcnt_nx = hcnt;
    vcnt_nx = vcnt;
    if (hs_edge)             hcnt_nx = '0;
    else if (hcnt != H_TOT)  hcnt_nx = hcnt + 11'd1;
    if (vs_edge)                      vcnt_nx = '0;
    else if (hs_edge && vcnt != V_TOT) vcnt_nx = vcnt + 10'd1;
  end

  // Off-length lines/frames, or a counter stepping into saturation.
  assign line_err  = hs_edge ? (hcnt != H_LAST) : (hcnt == H_LAST);
  assign frame_err = vs_edge ? (vcnt != V_LAST) : (hs_edge && (vcnt == V_LAST));
  assign any_err   = line_err | frame_err;

  assign in_active = (hcnt_nx >= H_START) && (hcnt_nx <= H_END) &&
                     (vcnt_nx >= V_START) && (vcnt_nx <= V_END);
  assign valid_nx  = (state_nx == LOCKED) && in_active;

  // lock FSM next-state; errors are ignored while UNLOCKED
  always_comb begin
    state_nx = state;
    clean_nx = clean_cnt;
    err_inc  = 1'b0;
    case (state)
      UNLOCKED: begin
        if (vs_edge) begin
          state_nx = ACQUIRE;
          clean_nx = '0;
        end
      end
      ACQUIRE: begin
        if (any_err) begin
          state_nx = UNLOCKED;
        end else if (vs_edge) begin
          clean_nx = clean_cnt + 8'd1;
          if (clean_nx == LOCK_N) state_nx = LOCKED;
        end
      end
      LOCKED: begin
        if (any_err) begin
          state_nx = UNLOCKED;
          err_inc  = 1'b1;
        end
      end
      default: state_nx = UNLOCKED;
    endcase
  end

  // FSM state and position counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= UNLOCKED;
      clean_cnt <= '0;
      hcnt      <= '0;
      vcnt      <= '0;
    end else begin
      state     <= state_nx;
      clean_cnt <= clean_nx;
      hcnt      <= hcnt_nx;
      vcnt      <= vcnt_nx;
    end
  end

  // registered outputs, two cycles behind the input pins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beam_x      <= '0;
      beam_y      <= '0;
      pixel_valid <= 1'b0;
      pixel_rgb   <= '0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      error_count <= '0;
    end else begin
      if (in_active) begin
        beam_x <= hcnt_nx - H_START;
        beam_y <= vcnt_nx - V_START;
      end
      pixel_valid <= valid_nx;
      pixel_rgb   <= valid_nx ? rgb_q : '0;
      locked      <= (state_nx == LOCKED);
      frame_start <= vs_edge && (state_nx == LOCKED);
      if (err_inc && (error_count != 8'hFF)) error_count <= error_count + 8'd1;
    end
  end

`ifdef VGA_DECODER_CHECKSUM_EN
  logic [15:0] csum_acc;

  // sum delivered pixels; publish and restart at each locked frame boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_acc       <= '0;
      frame_checksum <= '0;
    end else if (vs_edge && (state == LOCKED)) begin
      frame_checksum <= csum_acc;
      csum_acc       <= '0;
    end else if (state_nx != LOCKED) begin
      csum_acc <= '0;
    end else if (valid_nx) begin
      csum_acc <= csum_acc + {4'h0, rgb_q};
    end
  end
`else
  assign frame_checksum = '0;
`endif

endmodule
